// File: rtl/ps2_pkg.sv
// Purpose: shared types and constants for the PS/2 host transmit path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: state_t FSM encoding, FRAME_BITS, keyboard command bytes,
//           make_frame() which builds the serial frame sent after the start bit.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    START,
    SEND,
    ACK,
    WAIT_IDLE,
    DONE
  } state_t;

  // Bits shifted out after the start bit: 8 data, odd parity, stop.
  localparam int FRAME_BITS = 10;

  localparam logic [7:0] CMD_SET_LED  = 8'hED;
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] RESP_ACK     = 8'hFA;
  localparam logic [7:0] BREAK_PREFIX = 8'hF0;

  // {stop, odd parity, data}; bit 0 goes on the wire first.
  function automatic logic [FRAME_BITS-1:0] make_frame(input logic [7:0] d);
    return {1'b1, ~^d, d};
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Purpose: 2-flop synchronizers for the PS/2 clock and data lines plus a clock falling-edge pulse.
// Latency: synced lines lag the pins by 2 clk cycles; clk_fall is high in the cycle clk_sync first reads 0.
// Backpressure: none; free-running.
// Ports: clk, rst (sync, active-high) | ps2_clk_in, ps2_data_in raw async lines |
//        clk_sync, data_sync synchronized lines | clk_fall one-cycle fall pulse.
module ps2_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic ps2_clk_in,
  input  logic ps2_data_in,
  output logic clk_sync,
  output logic data_sync,
  output logic clk_fall
);

  logic [1:0] clk_ff;
  logic [1:0] data_ff;
  logic       clk_prev;

  // Reset to the idle-high line level so leaving reset cannot fake a fall.
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_ff   <= 2'b11;
      data_ff  <= 2'b11;
      clk_prev <= 1'b1;
    end else begin
      clk_ff   <= {clk_ff[0], ps2_clk_in};
      data_ff  <= {data_ff[0], ps2_data_in};
      clk_prev <= clk_ff[1];
    end
  end

  assign clk_sync  = clk_ff[1];
  assign data_sync = data_ff[1];
  assign clk_fall  = clk_prev & ~clk_ff[1];

endmodule

// File: rtl/ps2_host_tx.sv
// Purpose: PS/2 host-to-device transmitter; sends one byte and reports ACK / NACK / timeout.
// Latency: INHIBIT_CYCLES + START_HOLD_CYCLES, then 11 device clocks, then line-idle wait, then done.
// Backpressure: tx_ready is high only in IDLE; tx_valid at any other time is ignored.
// Ports: clk, rst (sync, active-high) | tx_data, tx_valid, tx_ready request handshake |
//        busy, done, err status | ps2_clk_in, ps2_data_in raw lines |
//        ps2_clk_drive_low, ps2_data_drive_low open-drain pull-down enables.
// Build option: define PS2_HOST_TX_RETRY_EN to retry once on NACK or timeout before reporting err.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES    = 10000,
  parameter int START_HOLD_CYCLES = 16,
  parameter int TIMEOUT_CYCLES    = 2000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       done,
  output logic       err,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_drive_low,
  output logic       ps2_data_drive_low
);

  localparam int CNT_MAX_A = (INHIBIT_CYCLES > START_HOLD_CYCLES) ? INHIBIT_CYCLES : START_HOLD_CYCLES;
  localparam int CNT_MAX   = (TIMEOUT_CYCLES > CNT_MAX_A) ? TIMEOUT_CYCLES : CNT_MAX_A;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] INH_LAST   = CNT_W'(INHIBIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT_CYCLES - 1);

  logic clk_sync, data_sync, clk_fall;

  ps2_line_sync u_sync (
    .clk         (clk),
    .rst         (rst),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .clk_sync    (clk_sync),
    .data_sync   (data_sync),
    .clk_fall    (clk_fall)
  );

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [3:0]            bitcnt_q, bitcnt_d;
  logic [FRAME_BITS-1:0] frame_q, frame_d;
  logic                  tx_ready_d, busy_d, done_d, err_d;
  logic                  clk_dl_d, data_dl_d;
  logic                  can_retry;

`ifdef PS2_HOST_TX_RETRY_EN
  logic retried_q, retried_d;
  assign can_retry = ~retried_q;

  always_ff @(posedge clk) begin
    if (rst) retried_q <= 1'b0;
    else     retried_q <= retried_d;
  end
`else
  assign can_retry = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bitcnt_d  = bitcnt_q;
    frame_d   = frame_q;
    done_d    = 1'b0;
    err_d     = err;
    clk_dl_d  = ps2_clk_drive_low;
    data_dl_d = ps2_data_drive_low;
`ifdef PS2_HOST_TX_RETRY_EN
    retried_d = retried_q;
`endif

    case (state_q)
      IDLE: begin
        clk_dl_d  = 1'b0;
        data_dl_d = 1'b0;
        if (tx_valid && tx_ready) begin
          frame_d  = make_frame(tx_data);
          cnt_d    = '0;
          bitcnt_d = '0;
          err_d    = 1'b0;
          clk_dl_d = 1'b1;
          state_d  = INHIBIT;
`ifdef PS2_HOST_TX_RETRY_EN
          retried_d = 1'b0;
`endif
        end
      end

      INHIBIT: begin
        clk_dl_d  = 1'b1;
        data_dl_d = 1'b0;
        if (cnt_q == INH_LAST) begin
          cnt_d     = '0;
          data_dl_d = 1'b1;  // start bit
          state_d   = START;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      START: begin
        if (cnt_q == START_LAST) begin
          cnt_d    = '0;  // timeout window opens here
          bitcnt_d = '0;
          clk_dl_d = 1'b0;
          state_d  = SEND;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      SEND, ACK: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == TO_LAST) begin
          // Timeout takes priority over a coincident clock fall.
          if (can_retry) begin
            cnt_d     = '0;
            clk_dl_d  = 1'b1;
            data_dl_d = 1'b0;
            err_d     = 1'b0;
            state_d   = INHIBIT;
`ifdef PS2_HOST_TX_RETRY_EN
            retried_d = 1'b1;
`endif
          end else begin
            clk_dl_d  = 1'b0;
            data_dl_d = 1'b0;
            err_d     = 1'b1;
            done_d    = 1'b1;
            state_d   = DONE;
          end
        end else if (clk_fall) begin
          if (state_q == SEND) begin
            data_dl_d = ~frame_q[bitcnt_q];
            bitcnt_d  = bitcnt_q + 1'b1;
            if (bitcnt_q == 4'(FRAME_BITS - 1)) state_d = ACK;
          end else begin
            err_d   = data_sync;  // device pulls data low to ACK
            state_d = WAIT_IDLE;
          end
        end
      end

      WAIT_IDLE: begin
        if (clk_sync && data_sync) begin
          if (err && can_retry) begin
            cnt_d     = '0;
            clk_dl_d  = 1'b1;
            data_dl_d = 1'b0;
            err_d     = 1'b0;
            state_d   = INHIBIT;
`ifdef PS2_HOST_TX_RETRY_EN
            retried_d = 1'b1;
`endif
          end else begin
            done_d  = 1'b1;
            state_d = DONE;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        clk_dl_d  = 1'b0;
        data_dl_d = 1'b0;
        state_d   = IDLE;
      end
    endcase

    tx_ready_d = (state_d == IDLE);
    busy_d     = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q            <= IDLE;
      cnt_q              <= '0;
      bitcnt_q           <= '0;
      frame_q            <= '0;
      tx_ready           <= 1'b0;
      busy               <= 1'b0;
      done               <= 1'b0;
      err                <= 1'b0;
      ps2_clk_drive_low  <= 1'b0;
      ps2_data_drive_low <= 1'b0;
    end else begin
      state_q            <= state_d;
      cnt_q              <= cnt_d;
      bitcnt_q           <= bitcnt_d;
      frame_q            <= frame_d;
      tx_ready           <= tx_ready_d;
      busy               <= busy_d;
      done               <= done_d;
      err                <= err_d;
      ps2_clk_drive_low  <= clk_dl_d;
      ps2_data_drive_low <= data_dl_d;
    end
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
`timescale 1ns/1ps
module tb_ps2_host_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, busy, done, err;
  logic       ps2_clk_drive_low, ps2_data_drive_low;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;
  logic       ps2_clk_in, ps2_data_in;

  // Wired-AND open-drain bus with pull-ups.
  assign ps2_clk_in  = ~(ps2_clk_drive_low | dev_clk_low);
  assign ps2_data_in = ~(ps2_data_drive_low | dev_data_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES    (20),
    .START_HOLD_CYCLES (4),
    .TIMEOUT_CYCLES    (2000)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .tx_data            (tx_data),
    .tx_valid           (tx_valid),
    .tx_ready           (tx_ready),
    .busy               (busy),
    .done               (done),
    .err                (err),
    .ps2_clk_in         (ps2_clk_in),
    .ps2_data_in        (ps2_data_in),
    .ps2_clk_drive_low  (ps2_clk_drive_low),
    .ps2_data_drive_low (ps2_data_drive_low)
  );

  always #5 clk = ~clk;

  int vec = 0;
  int mis = 0;

  // Monitor: samples 1 ns after each rising edge; tasks act on falling edges.
  int   cyc = 0;
  int   done_cnt = 0;
  int   done_cyc = 0;
  int   send_cyc = 0;
  logic done_err = 1'b0;
  logic prev_cdl = 1'b0;
  always @(posedge clk) begin
    #1;
    cyc++;
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
      done_err = err;
    end
    if (prev_cdl && !ps2_clk_drive_low && ps2_data_drive_low) send_cyc = cyc;
    prev_cdl = ps2_clk_drive_low;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, want finish before 900 us");
    $fatal(1, "watchdog");
  end

  task automatic start_tx(input logic [7:0] d, output bit ok);
    @(negedge clk);
    tx_data  = d;
    tx_valid = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (busy) break;
    end
    tx_valid = 1'b0;
    ok = busy;
  endtask

  // Device model: waits for request-to-send, then 20-low/20-high clocks,
  // sampling data at each rising edge; optionally ACKs on the 11th clock.
  task automatic dev_frame(input int npulse, input bit ack, output logic [9:0] bits,
                           output int inh, output int stc, output bit ok);
    bits = '0;
    inh  = 0;
    stc  = 0;
    ok   = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if (!ps2_clk_drive_low && ps2_data_drive_low) begin
        ok = 1'b1;
        break;
      end
      if (ps2_clk_drive_low && !ps2_data_drive_low) inh++;
      if (ps2_clk_drive_low && ps2_data_drive_low)  stc++;
      @(negedge clk);
    end
    if (ok) begin
      repeat (20) @(negedge clk);
      for (int k = 1; k <= npulse; k++) begin
        dev_clk_low = 1'b1;
        repeat (20) @(negedge clk);
        dev_clk_low = 1'b0;
        if (k <= 10) bits[k-1] = ps2_data_in;
        repeat (10) @(negedge clk);
        if (k == 10 && ack && npulse == 11) dev_data_low = 1'b1;
        repeat (10) @(negedge clk);
      end
      dev_data_low = 1'b0;
    end
  endtask

  task automatic wait_done(input int d0, input int bound, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < bound; n++) begin
      if (done_cnt != d0) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    vec++; if (tx_ready !== 1'b0) begin mis++; $display("FAIL reset_tx_ready: got %b want 0", tx_ready); end
    vec++; if (busy !== 1'b0) begin mis++; $display("FAIL reset_busy: got %b want 0", busy); end
    vec++; if (done !== 1'b0 || err !== 1'b0) begin mis++; $display("FAIL reset_done_err: got %b%b want 00", done, err); end
    vec++; if ({ps2_clk_drive_low, ps2_data_drive_low} !== 2'b00) begin
      mis++; $display("FAIL reset_drives: got %b%b want 00", ps2_clk_drive_low, ps2_data_drive_low);
    end
    rst = 1'b0;
    @(negedge clk);
    vec++; if (tx_ready !== 1'b1) begin mis++; $display("FAIL reset_release_ready: got %b want 1", tx_ready); end
  endtask

  task automatic test_send_ed();
    bit ok; int inh, stc, d0; logic [9:0] bits;
    d0 = done_cnt;
    start_tx(8'hED, ok);
    vec++; if (ok !== 1'b1) begin mis++; $display("FAIL ed_accept: busy=%b want 1", ok); end
    dev_frame(11, 1'b1, bits, inh, stc, ok);
    vec++; if (ok !== 1'b1) begin mis++; $display("FAIL ed_rts: seen=%b want 1", ok); end
    vec++; if (inh !== 20) begin mis++; $display("FAIL ed_inhibit_len: got %0d want 20", inh); end
    vec++; if (stc !== 4) begin mis++; $display("FAIL ed_start_len: got %0d want 4", stc); end
    vec++; if (bits !== 10'h3ED) begin mis++; $display("FAIL ed_bits: got %h want 3ed", bits); end
    wait_done(d0, 300, ok);
    vec++; if (ok !== 1'b1) begin mis++; $display("FAIL ed_done_seen: got %b want 1", ok); end
    vec++; if (err !== 1'b0) begin mis++; $display("FAIL ed_err: got %b want 0", err); end
    repeat (5) @(negedge clk);
    vec++; if (done_cnt - d0 !== 1) begin mis++; $display("FAIL ed_done_width: got %0d cycles want 1", done_cnt - d0); end
    vec++; if (tx_ready !== 1'b1 || busy !== 1'b0) begin mis++; $display("FAIL ed_idle: ready=%b busy=%b want 1 0", tx_ready, busy); end
  endtask

  task automatic test_parity();
    logic [7:0] pd [2];
    logic [9:0] pb [2];
    bit ok; int inh, stc, d0; logic [9:0] bits;
    pd[0] = 8'h07; pb[0] = 10'h207;
    pd[1] = 8'h00; pb[1] = 10'h300;
    for (int i = 0; i < 2; i++) begin
      d0 = done_cnt;
      start_tx(pd[i], ok);
      dev_frame(11, 1'b1, bits, inh, stc, ok);
      vec++; if (bits !== pb[i]) begin mis++; $display("FAIL parity_bits_%h: got %h want %h", pd[i], bits, pb[i]); end
      wait_done(d0, 300, ok);
      vec++; if (ok !== 1'b1 || err !== 1'b0) begin
        mis++; $display("FAIL parity_done_%h: done=%b err=%b want 1 0", pd[i], ok, err);
      end
      repeat (5) @(negedge clk);
    end
  endtask

  task automatic test_nack();
    bit ok; int inh, stc, d0; logic [9:0] bits;
    d0 = done_cnt;
    start_tx(8'hED, ok);
    dev_frame(11, 1'b0, bits, inh, stc, ok);
`ifdef PS2_HOST_TX_RETRY_EN
    vec++; if (done_cnt !== d0 || busy !== 1'b1) begin
      mis++; $display("FAIL nack_retry_silent: dones=%0d busy=%b want 0 1", done_cnt - d0, busy);
    end
    dev_frame(11, 1'b0, bits, inh, stc, ok);
    vec++; if (ok !== 1'b1 || bits !== 10'h3ED) begin mis++; $display("FAIL nack_retry_bits: got %h want 3ed", bits); end
`endif
    wait_done(d0, 300, ok);
    vec++; if (ok !== 1'b1) begin mis++; $display("FAIL nack_done_seen: got %b want 1", ok); end
    vec++; if (err !== 1'b1) begin mis++; $display("FAIL nack_err: got %b want 1", err); end
    repeat (3) @(negedge clk);
    vec++; if (err !== 1'b1) begin mis++; $display("FAIL nack_err_held: got %b want 1", err); end
`ifdef PS2_HOST_TX_RETRY_EN
    d0 = done_cnt;
    start_tx(8'hED, ok);
    dev_frame(11, 1'b0, bits, inh, stc, ok);
    dev_frame(11, 1'b1, bits, inh, stc, ok);
    wait_done(d0, 300, ok);
    vec++; if (ok !== 1'b1 || err !== 1'b0) begin mis++; $display("FAIL nack_then_ack: done=%b err=%b want 1 0", ok, err); end
    repeat (3) @(negedge clk);
`endif
  endtask

  task automatic test_timeout();
    bit ok; int d0;
    d0 = done_cnt;
    start_tx(8'h07, ok);
    wait_done(d0, 6000, ok);
    vec++; if (ok !== 1'b1) begin mis++; $display("FAIL timeout_done_seen: got %b want 1", ok); end
    vec++; if (done_cyc - send_cyc !== 2000) begin
      mis++; $display("FAIL timeout_latency: got %0d want 2000", done_cyc - send_cyc);
    end
    vec++; if (err !== 1'b1) begin mis++; $display("FAIL timeout_err: got %b want 1", err); end
    vec++; if ({ps2_clk_drive_low, ps2_data_drive_low} !== 2'b00) begin
      mis++; $display("FAIL timeout_release: got %b%b want 00", ps2_clk_drive_low, ps2_data_drive_low);
    end
    repeat (3) @(negedge clk);
    vec++; if (done_cnt - d0 !== 1) begin mis++; $display("FAIL timeout_done_width: got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_reset_midframe();
    bit ok; int inh, stc, d0; logic [9:0] bits;
    d0 = done_cnt;
    start_tx(8'h00, ok);
    dev_frame(4, 1'b1, bits, inh, stc, ok);
    vec++; if (ps2_data_drive_low !== 1'b1) begin mis++; $display("FAIL midrst_pre_data: got %b want 1", ps2_data_drive_low); end
    rst = 1'b1;
    @(negedge clk);
    vec++; if ({ps2_clk_drive_low, ps2_data_drive_low} !== 2'b00) begin
      mis++; $display("FAIL midrst_release: got %b%b want 00", ps2_clk_drive_low, ps2_data_drive_low);
    end
    vec++; if (busy !== 1'b0) begin mis++; $display("FAIL midrst_busy: got %b want 0", busy); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    vec++; if (tx_ready !== 1'b1) begin mis++; $display("FAIL midrst_ready: got %b want 1", tx_ready); end
    repeat (20) @(negedge clk);
    vec++; if (done_cnt !== d0) begin mis++; $display("FAIL midrst_no_done: got %0d pulses want 0", done_cnt - d0); end
  endtask

  task automatic test_back_to_back();
    bit ok; int inh, stc, d0; logic [9:0] bits;
    d0 = done_cnt;
    @(negedge clk);
    tx_data  = 8'hFF;
    tx_valid = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (busy) break;
    end
    tx_data = 8'hF0;
    dev_frame(11, 1'b1, bits, inh, stc, ok);
    vec++; if (bits !== 10'h3FF) begin mis++; $display("FAIL b2b_first_bits: got %h want 3ff", bits); end
    wait_done(d0, 300, ok);
    vec++; if (ok !== 1'b1) begin mis++; $display("FAIL b2b_first_done: got %b want 1", ok); end
    @(negedge clk);
    vec++; if (tx_ready !== 1'b1) begin mis++; $display("FAIL b2b_ready_return: got %b want 1", tx_ready); end
    @(negedge clk);
    vec++; if (busy !== 1'b1 || tx_ready !== 1'b0) begin
      mis++; $display("FAIL b2b_second_accept: busy=%b ready=%b want 1 0", busy, tx_ready);
    end
    tx_valid = 1'b0;
    dev_frame(11, 1'b1, bits, inh, stc, ok);
    vec++; if (inh !== 20) begin mis++; $display("FAIL b2b_second_inhibit: got %0d want 20", inh); end
    vec++; if (bits !== 10'h3F0) begin mis++; $display("FAIL b2b_second_bits: got %h want 3f0", bits); end
    wait_done(d0 + 1, 300, ok);
    vec++; if (ok !== 1'b1 || err !== 1'b0) begin mis++; $display("FAIL b2b_second_done: done=%b err=%b want 1 0", ok, err); end
    repeat (30) @(negedge clk);
    vec++; if (busy !== 1'b0 || done_cnt - d0 !== 2) begin
      mis++; $display("FAIL b2b_no_third: busy=%b dones=%0d want 0 2", busy, done_cnt - d0);
    end
  endtask

  initial begin
    test_reset();
    test_send_ed();
    test_parity();
    test_nack();
    test_timeout();
    test_reset_midframe();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
    $finish;
  end

endmodule
